// File: rtl/mul_float_pkg.sv
// rtl/mul_float_pkg.sv - shared FSM encoding, flag indices and defaults for the mul_float driver
package mul_float_pkg;

    localparam int DEFAULT_FLOAT_WIDTH = 32;

    localparam int FLAG_NAN  = 3;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } drv_state_t;

endpackage

// File: rtl/mul_float_driver_sync_fifo.sv
// rtl/mul_float_driver_sync_fifo.sv - power-of-2 synchronous FIFO with registered not-full ready
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             w_push;
    logic             w_pop;

    // A push while full is legal only when the same cycle frees an entry.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            o_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            o_ready <= (w_count_nxt != FULL_CNT);
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/mul_float_driver.sv
// rtl/mul_float_driver.sv - queues operand pairs and drives a mul_float start/done handshake; MUL_DRV_TIMEOUT_EN adds a WAIT abort
module mul_float_driver
    import mul_float_pkg::*;
#(
    parameter int FLOAT_WIDTH    = DEFAULT_FLOAT_WIDTH,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] in_op1,
    input  logic [FLOAT_WIDTH-1:0] in_op2,
    output logic                   mul_start,
    output logic [FLOAT_WIDTH-1:0] mul_op1,
    output logic [FLOAT_WIDTH-1:0] mul_op2,
    input  logic [FLOAT_WIDTH-1:0] mul_out,
    input  logic                   mul_nan,
    input  logic                   mul_overflow,
    input  logic                   mul_underflow,
    input  logic                   mul_zero,
    input  logic                   mul_done,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [FLOAT_WIDTH-1:0] res_data,
    output logic [3:0]             res_flags,
    output logic                   res_timeout
);
    drv_state_t               r_state;
    logic                     r_done_q;
    logic [2*FLOAT_WIDTH-1:0] w_head;
    logic                     w_empty;
    logic                     w_pop;
    logic                     w_done_edge;
    logic                     w_expire;
    logic [3:0]               w_flags;

    // Head is consumed on the same edge it is loaded into mul_op1/mul_op2.
    assign w_pop = !w_empty && ((r_state == ST_IDLE) ||
                                ((r_state == ST_HOLD) && res_ready));

    sync_fifo #(
        .WIDTH(2 * FLOAT_WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (in_valid && in_ready),
        .i_wdata({in_op1, in_op2}),
        .i_pop  (w_pop),
        .o_rdata(w_head),
        .o_empty(w_empty),
        .o_ready(in_ready)
    );

    // Only a rising edge completes an operation, so a done level left over from the previous op is ignored.
    assign w_done_edge = mul_done && !r_done_q;

    always_comb begin
        w_flags            = '0;
        w_flags[FLAG_NAN]  = mul_nan;
        w_flags[FLAG_OVF]  = mul_overflow;
        w_flags[FLAG_UNF]  = mul_underflow;
        w_flags[FLAG_ZERO] = mul_zero;
    end

`ifdef MUL_DRV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_WAIT)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_expire = (r_state == ST_WAIT) && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_done_q    <= 1'b0;
            mul_start   <= 1'b0;
            mul_op1     <= '0;
            mul_op2     <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_flags   <= '0;
            res_timeout <= 1'b0;
        end else begin
            r_done_q  <= mul_done;
            mul_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        {mul_op1, mul_op2} <= w_head;
                        mul_start          <= 1'b1;
                        r_state            <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done_edge) begin
                        res_data    <= mul_out;
                        res_flags   <= w_flags;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else if (w_expire) begin
                        res_data    <= '0;
                        res_flags   <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (!w_empty) begin
                            {mul_op1, mul_op2} <= w_head;
                            mul_start          <= 1'b1;
                            r_state            <= ST_ISSUE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_float_driver.sv
// tb/tb_mul_float_driver.sv - self-checking bench for mul_float_driver with a behavioural multiplier stub
module tb_mul_float_driver;
    localparam int FW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_op1;
    logic [FW-1:0] in_op2;
    logic          mul_start;
    logic [FW-1:0] mul_op1;
    logic [FW-1:0] mul_op2;
    logic [FW-1:0] mul_out;
    logic          mul_nan;
    logic          mul_overflow;
    logic          mul_underflow;
    logic          mul_zero;
    logic          mul_done;
    logic          res_valid;
    logic          res_ready;
    logic [FW-1:0] res_data;
    logic [3:0]    res_flags;
    logic          res_timeout;

    always #10 clk = ~clk;

    mul_float_driver #(
        .FLOAT_WIDTH(FW),
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op1(in_op1), .in_op2(in_op2),
        .mul_start(mul_start), .mul_op1(mul_op1), .mul_op2(mul_op2),
        .mul_out(mul_out), .mul_nan(mul_nan), .mul_overflow(mul_overflow),
        .mul_underflow(mul_underflow), .mul_zero(mul_zero), .mul_done(mul_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .res_timeout(res_timeout)
    );

    // Multiplier behaviour: exact IEEE products for the known pairs, an arbitrary mixing function otherwise.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] key;
        key = {a, b};
        case (key)
            64'h40a00000_40a00000: return {4'b0000, 32'h41c80000};
            64'h00000000_3f800000: return {4'b0001, 32'h00000000};
            64'h3f800000_3f800000: return {4'b0000, 32'h3f800000};
            64'hc0000000_40400000: return {4'b0000, 32'hc0c00000};
            64'h7f7fffff_40000000: return {4'b0100, 32'h7f800000};
            64'h7fc00000_3f800000: return {4'b1000, 32'h7fc00000};
            default:               return {a[3:0] ^ b[7:4], a ^ {b[15:0], b[31:16]}};
        endcase
    endfunction

    logic        stub_en = 1'b1;
    int          stub_lat = 1;
    int          stub_cnt = 0;
    logic        stub_done = 1'b0;
    logic [35:0] stub_res = '0;
    logic [31:0] s_a = '0;
    logic [31:0] s_b = '0;
    logic        man_done = 1'b0;
    logic [35:0] man_res = '0;

    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (mul_start) begin
            stub_cnt <= stub_lat;
            s_a      <= mul_op1;
            s_b      <= mul_op2;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                stub_done <= 1'b1;
                stub_res  <= ref_mul(s_a, s_b);
            end
        end
    end

    assign mul_done = stub_en ? stub_done : man_done;
    assign {mul_nan, mul_overflow, mul_underflow, mul_zero, mul_out} = stub_en ? stub_res : man_res;

    logic rr_mode = 1'b0;
    logic rr_fixed = 1'b1;
    logic rr_rand = 1'b1;
    always @(posedge clk) rr_rand <= 1'($urandom_range(0, 1));
    assign res_ready = rr_mode ? rr_rand : rr_fixed;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  f;
        logic        t;
    } res_t;

    // Monitor only records what it sees; all judging happens in the main sequence.
    res_t obs[$];
    int   starts = 0;
    int   dups = 0;
    int   unstable = 0;
    logic inflight = 1'b0;
    logic held = 1'b0;
    res_t held_v;

    always @(negedge clk) begin
        res_t cur;
        cur = '{d: res_data, f: res_flags, t: res_timeout};
        if (rst) begin
            inflight = 1'b0;
            held     = 1'b0;
        end else begin
            if (mul_start) begin
                starts++;
                if (inflight) dups++;
                inflight = 1'b1;
            end
            if (res_valid) begin
                if (held && (held_v != cur)) unstable++;
                if (res_ready) begin
                    obs.push_back(cur);
                    inflight = 1'b0;
                    held     = 1'b0;
                end else begin
                    held   = 1'b1;
                    held_v = cur;
                end
            end
        end
    end

    int   total = 0;
    int   bad = 0;
    int   rd = 0;
    res_t expq[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [3:0]  f;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_op1   = a;
        in_op2   = b;
        for (int n = 0; n < 300 && !ok; n++) begin
            if (in_ready) ok = 1'b1;
            tick(1);
        end
        in_valid = 1'b0;
        if (!ok) chk("push_accept", 64'(0), 64'(1));
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        logic [35:0] r;
        push(a, b);
        r = ref_mul(a, b);
        expq.push_back('{d: r[31:0], f: r[35:32], t: 1'b0});
    endtask

    task automatic wait_start(input string name);
        for (int n = 0; n < 50; n++) begin
            if (mul_start) break;
            tick(1);
        end
        chk({name, "_start"}, 64'(mul_start), 64'(1));
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 600; n++) begin
            if (((obs.size() - rd) >= expq.size()) && !res_valid) break;
            tick(1);
        end
        chk({name, "_count"}, 64'(obs.size() - rd), 64'(expq.size()));
        while ((rd < obs.size()) && (expq.size() > 0)) begin
            chk(name, 64'(obs[rd]), 64'(expq[0]));
            void'(expq.pop_front());
            rd++;
        end
        expq.delete();
        rd = obs.size();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   s0;
        int   n;
        logic seen;
        res_t tr;

        vecs[0] = '{32'h40a00000, 32'h40a00000, 32'h41c80000, 4'b0000};
        vecs[1] = '{32'h00000000, 32'h3f800000, 32'h00000000, 4'b0001};
        vecs[2] = '{32'h3f800000, 32'h3f800000, 32'h3f800000, 4'b0000};
        vecs[3] = '{32'hc0000000, 32'h40400000, 32'hc0c00000, 4'b0000};
        vecs[4] = '{32'h7f7fffff, 32'h40000000, 32'h7f800000, 4'b0100};
        vecs[5] = '{32'h7fc00000, 32'h3f800000, 32'h7fc00000, 4'b1000};

        rst = 1'b1; in_valid = 1'b0; in_op1 = '0; in_op2 = '0;
        tick(3);
        chk("reset_state", 64'({res_valid, in_ready, mul_start, res_timeout, res_flags, res_data}),
            64'({1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0}));
        chk("reset_ops", 64'({mul_op1, mul_op2}), 64'(0));
        rst = 1'b0;
        tick(1);

        // Basic: one start pulse and minimum latency of 3 + multiplier latency.
        stub_lat = 1;
        s0 = starts;
        push(vecs[0].a, vecs[0].b);
        expq.push_back('{d: vecs[0].d, f: vecs[0].f, t: 1'b0});
        n = 0;
        while (!res_valid && n < 30) begin tick(1); n++; end
        chk("latency", 64'(n), 64'(3 + 1));
        drain("basic");
        chk("basic_one_start", 64'(starts - s0), 64'(1));

        for (int i = 1; i < 6; i++) begin
            stub_lat = i;
            push(vecs[i].a, vecs[i].b);
            expq.push_back('{d: vecs[i].d, f: vecs[i].f, t: 1'b0});
            drain("vector");
        end

        // Back-pressure: five pairs fill the queue behind the held first result.
        stub_lat = 3;
        rr_fixed = 1'b0;
        s0 = starts;
        for (int i = 0; i < 5; i++) send($urandom, $urandom);
        chk("in_ready_full", 64'(in_ready), 64'(0));
        tick(10);
        chk("hold_valid", 64'(res_valid), 64'(1));
        chk("hold_data", 64'({res_data, res_flags}), 64'({expq[0].d, expq[0].f}));
        rr_fixed = 1'b1;
        drain("backpressure");
        chk("bp_starts", 64'(starts - s0), 64'(5));

        // Reset two cycles into WAIT; the stale operation must never produce a result.
        stub_lat = 10;
        push(32'h12345678, 32'h9abcdef0);
        wait_start("rst_mid");
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_outputs", 64'({res_valid, in_ready, mul_start}), 64'({1'b0, 1'b1, 1'b0}));
        rst = 1'b0;
        tick(15);
        chk("rst_no_result", 64'(obs.size() - rd), 64'(0));
        rd = obs.size();
        stub_lat = 2;
        send(32'h40a00000, 32'h40a00000);
        drain("after_rst");

        // Stale done: level stays high across two operations.
        stub_en  = 1'b0;
        man_done = 1'b0;
        send(32'h11112222, 32'h33334444);
        wait_start("stale1");
        tick(3);
        man_res  = ref_mul(32'h11112222, 32'h33334444);
        man_done = 1'b1;
        drain("stale1");
        send(32'h55556666, 32'h77778888);
        wait_start("stale2");
        tick(6);
        chk("stale_no_complete", 64'({res_valid, 32'(obs.size() - rd)}), 64'(0));
        man_res  = ref_mul(32'h55556666, 32'h77778888);
        man_done = 1'b0;
        tick(1);
        man_done = 1'b1;
        drain("stale2");
        man_done = 1'b0;
        tick(2);

        // Multiplier never answers.
        send(32'hdeadbeef, 32'h01020304);
        wait_start("tmo");
`ifdef MUL_DRV_TIMEOUT_EN
        tr = '{d: 32'h0, f: 4'h0, t: 1'b1};
        void'(expq.pop_back());
        expq.push_back(tr);
        n = 0;
        while (!res_valid && n < 50) begin tick(1); n++; end
        chk("timeout_cycle", 64'(n), 64'(TMO + 1));
        drain("timeout");
`else
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (res_valid) seen = 1'b1;
            tick(1);
        end
        chk("no_timeout", 64'(seen), 64'(0));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expq.delete();
        rd = obs.size();
        tick(1);
`endif

        // Randomized traffic with random latency, gaps and consumer stalls.
        stub_en = 1'b1;
        rr_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            stub_lat = $urandom_range(1, 5);
            send($urandom, $urandom);
            tick($urandom_range(0, 2));
        end
        drain("random");
        rr_mode = 1'b0;

        chk("dup_starts", 64'(dups), 64'(0));
        chk("unstable_result", 64'(unstable), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
